multi_arbiter: RTL and testbench

Round-robin front-end that shares one fully pipelined multiplier between `R` independent requesters. Each requester presents operands through a valid/ready handshake; the block grants at most one request per cycle, drives the multiplier's operand and enable inputs, tracks which requester owns each in-flight product, and returns every product to its owner with a one-hot result strobe. It sits between client logic and the multiplier core, and is the only block that drives the core's inputs.

---
 rtl/multi_arbiter.sv | 90 +++++++++
 tb/tb_multi_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/multi_arbiter.sv
// multi_arbiter: round-robin front-end sharing one pipelined multiplier between R requesters
module multi_arbiter #(
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req_valid,
  input  logic [R*M-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [R-1:0]     req_ready,
  output logic [M-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic             mul_en,
  input  logic [M+N-1:0]   mul_result,
  output logic [R-1:0]     res_valid,
  output logic [M+N-1:0]   res_data,
  output logic             busy
);
  localparam int LW = $clog2(R);
  localparam int TW = LAT * LW;
  logic [LW-1:0]  last_q, last_d, id_q, id_d, gnt_id, idx, out_id;
  logic [R-1:0]   gnt, res_valid_q, res_valid_d;
  logic           found, xfer, mul_en_q, mul_en_d;
  logic [M-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [LAT-1:0] tv_q, tv_d;
  logic [TW-1:0]  tid_q, tid_d;
  logic [M+N-1:0] res_data_q, res_data_d;
  // search starts just past the last winner and wraps modulo R
  always_comb begin
    gnt = '0;
    gnt_id = last_q;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= R; k++) begin
      idx = LW'((int'(last_q) + k) % R);
      if (!found && req_valid[idx] && rst_n) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    xfer = |gnt;
    last_d = xfer ? gnt_id : last_q;
    mul_en_d = xfer;
    mul_a_d = xfer ? req_a[gnt_id*M +: M] : mul_a_q;
    mul_b_d = xfer ? req_b[gnt_id*N +: N] : mul_b_q;
    id_d = xfer ? gnt_id : id_q;
    tv_d = LAT'({tv_q, mul_en_q});
    tid_d = TW'({tid_q, id_q});
    out_id = tid_q[TW-1 -: LW];
    res_valid_d = tv_q[LAT-1] ? R'(1) << out_id : '0;
    res_data_d = tv_q[LAT-1] ? mul_result : res_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= LW'(R - 1);
      id_q <= '0;
      mul_en_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
      res_valid_q <= '0;
      res_data_q <= '0;
    end else begin
      last_q <= last_d;
      id_q <= id_d;
      mul_en_q <= mul_en_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      tv_q <= tv_d;
      tid_q <= tid_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
    end
  end
  assign req_ready = gnt;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_en    = mul_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = mul_en_q | (|tv_q);
endmodule

// File: tb/tb_multi_arbiter.sv
// tb_multi_arbiter: directed bench for multi_arbiter with a behavioural pipelined multiplier
module tb_multi_arbiter;
  localparam int LAT = 4;
  logic        clk, rst_n;
  logic [3:0]  req_valid, req_ready, mul_a, mul_b, res_valid;
  logic [15:0] req_a, req_b;
  logic        mul_en, busy;
  logic [7:0]  mul_result, res_data;
  logic [7:0]  mp [LAT];
  logic [3:0]  vv [16];
  logic [3:0]  gg [16];
  logic [7:0]  dd [16];
  logic [7:0]  pf [4];
  logic [3:0]  mg [3];
  int comps = 0;
  int errs  = 0;

  multi_arbiter #(.M(4), .N(4), .R(4), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .mul_result(mul_result), .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mp[0] <= 8'(mul_a) * 8'(mul_b);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_result = mp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // steps t=0..n-1 drive vv[t]; results land at t+6; busy must be low at n+6
  task automatic burst(input string name, input int n);
    for (int t = 0; t <= n + 6; t++) begin
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = (t < n) ? vv[t] : 4'h0;
      #1;
      if (t < n) chk($sformatf("%s_grant%0d", name, t), 32'(req_ready), 32'(gg[t]));
      if (t >= 1 && t <= n) chk($sformatf("%s_mul_en%0d", name, t), 32'(mul_en), 32'd1);
      if (t >= 6 && t - 6 < n) begin
        chk($sformatf("%s_res_valid%0d", name, t - 6), 32'(res_valid), 32'(gg[t-6]));
        chk($sformatf("%s_res_data%0d", name, t - 6), 32'(res_data), 32'(dd[t-6]));
      end
      if (t == n + 6) begin
        chk($sformatf("%s_busy_end", name), 32'(busy), 32'd0);
        chk($sformatf("%s_res_valid_end", name), 32'(res_valid), 32'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'h0;
    req_a = 16'hFC21;
    req_b = 16'hFB79;
    pf[0] = 8'h09; pf[1] = 8'h0E; pf[2] = 8'h84; pf[3] = 8'hE1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mul_en", 32'(mul_en), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    vv[0] = 4'hF; gg[0] = 4'b0001; dd[0] = 8'h09;
    burst("release", 1);
    req_a = 16'hFF21; req_b = 16'hFF79;
    vv[0] = 4'b0100; gg[0] = 4'b0100; dd[0] = 8'hE1;
    burst("single", 1);
    req_a = 16'hFC21; req_b = 16'hFB79;
    vv[0] = 4'b1000; gg[0] = 4'b1000; dd[0] = 8'hE1;
    vv[1] = 4'b0110; gg[1] = 4'b0010; dd[1] = 8'h0E;
    vv[2] = 4'b0110; gg[2] = 4'b0100; dd[2] = 8'h84;
    vv[3] = 4'b1000; gg[3] = 4'b1000; dd[3] = 8'hE1;
    burst("wrap", 4);
    for (int i = 0; i < 12; i++) begin
      vv[i] = 4'hF;
      gg[i] = 4'b0001 << (i % 4);
      dd[i] = pf[i % 4];
    end
    burst("fair", 12);
    req_a = 16'hFC73; req_b = 16'hFB95;
    vv[0] = 4'b0001; gg[0] = 4'b0001; dd[0] = 8'h0F;
    vv[1] = 4'b0010; gg[1] = 4'b0010; dd[1] = 8'h3F;
    burst("b2b", 2);
    req_a = 16'hFC21; req_b = 16'hFB79;
    mg[0] = 4'b0100; mg[1] = 4'b1000; mg[2] = 4'b0001;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      rst_n = (t != 4);
      req_valid = (t < 3 || t == 4) ? 4'hF : 4'h0;
      #1;
      if (t < 3) chk($sformatf("midrst_grant%0d", t), 32'(req_ready), 32'(mg[t]));
      if (t == 4) chk("midrst_ready_in_reset", 32'(req_ready), 32'd0);
      if (t == 5) chk("midrst_busy", 32'(busy), 32'd0);
      if (t >= 5) chk($sformatf("midrst_no_result%0d", t), 32'(res_valid), 32'd0);
    end
    vv[0] = 4'b0010; gg[0] = 4'b0010; dd[0] = 8'h0E;
    burst("after_rst", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end
endmodule
